// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: read-tracking FSM states, access-width
// codes and the bundled access fields that the arbiter steers onto the memory port.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CORE = 2'd1,
    RD_DBG  = 2'd2
  } arb_state_t;

  // Width/sign codes carried on *_width; the arbiter passes them through untouched.
  localparam logic [2:0] WIDTH_B  = 3'b000;
  localparam logic [2:0] WIDTH_H  = 3'b001;
  localparam logic [2:0] WIDTH_W  = 3'b010;
  localparam logic [2:0] WIDTH_BU = 3'b100;
  localparam logic [2:0] WIDTH_HU = 3'b101;

  localparam int WAIT_CNT_W = 8;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  width;
  } mem_access_t;

  // Steers the granted requester's fields onto the memory port; all-zero when idle.
  function automatic mem_access_t sel_access(input logic core_sel, input logic dbg_sel,
                                             input mem_access_t core_acc,
                                             input mem_access_t dbg_acc);
    mem_access_t acc;
    acc = '0;
    if (core_sel) acc = core_acc;
    else if (dbg_sel) acc = dbg_acc;
    return acc;
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating starvation counter: counts cycles a debug request sits ungranted and
// flags when the count has reached the configured limit.
module arb_wait_counter
  import dmem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  clr,
  input  logic [WAIT_CNT_W-1:0] limit,
  output logic                  at_limit
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < limit)) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master (core, debug) arbiter for a single-cycle-latency data memory port.
// Optional feature: define DMEM_ARB_LOCK_EN to add the dbg_lock exclusive-hold input.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_width,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,

  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [2:0]  dbg_width,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,

`ifdef DMEM_ARB_LOCK_EN
  input  logic        dbg_lock,
`endif

  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_width,
  input  logic [31:0] mem_rdata
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

  arb_state_t  state_q, state_d;
  logic        core_gnt_d, dbg_gnt_d;
  logic        dbg_starved;
  logic        lock_d;
  mem_access_t core_acc, dbg_acc, mem_acc;

`ifdef DMEM_ARB_LOCK_EN
  assign lock_d = dbg_lock;
`else
  assign lock_d = 1'b0;
`endif

  assign core_acc = '{we: core_we, addr: core_addr, wdata: core_wdata, width: core_width};
  assign dbg_acc  = '{we: dbg_we,  addr: dbg_addr,  wdata: dbg_wdata,  width: dbg_width};

  // Grant decision is purely combinational so the memory sees the access in the
  // request cycle; reset masks every grant so nothing reaches memory while held.
  always_comb begin
    core_gnt_d = 1'b0;
    dbg_gnt_d  = 1'b0;
    if (!reset) begin
      if (lock_d) begin
        dbg_gnt_d = dbg_req;
      end else if (dbg_req && (dbg_starved || !core_req)) begin
        dbg_gnt_d = 1'b1;
      end else begin
        core_gnt_d = core_req;
      end
    end
  end

  arb_wait_counter u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (dbg_req && !dbg_gnt_d),
    .clr      (dbg_gnt_d),
    .limit    (WAIT_LIMIT),
    .at_limit (dbg_starved)
  );

  always_comb begin
    state_d = IDLE;
    if (core_gnt_d && !core_we) begin
      state_d = RD_CORE;
    end else if (dbg_gnt_d && !dbg_we) begin
      state_d = RD_DBG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign mem_acc = sel_access(core_gnt_d, dbg_gnt_d, core_acc, dbg_acc);

  // Read return path: the state register names the owner of this cycle's mem_rdata.
  // Reset also masks it so an in-flight read never surfaces.
  always_comb begin
    core_gnt    = core_gnt_d;
    dbg_gnt     = dbg_gnt_d;
    mem_en      = core_gnt_d | dbg_gnt_d;
    mem_we      = mem_acc.we;
    mem_addr    = mem_acc.addr;
    mem_wdata   = mem_acc.wdata;
    mem_width   = mem_acc.width;
    core_rvalid = 1'b0;
    dbg_rvalid  = 1'b0;
    core_rdata  = '0;
    dbg_rdata   = '0;
    if (!reset) begin
      if (state_q == RD_CORE) begin
        core_rvalid = 1'b1;
        core_rdata  = mem_rdata;
      end
      if (state_q == RD_DBG) begin
        dbg_rvalid = 1'b1;
        dbg_rdata  = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference model predicts grants and memory
// fields each cycle and queues expected read returns for the following cycle.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int          MAX_WAIT = 8;
  localparam logic [31:0] RD_KEY   = 32'hC3C3_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [2:0]  core_width = '0;
  logic        core_gnt, core_rvalid;
  logic [31:0] core_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic [2:0]  dbg_width = '0;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic        dbg_lock = 1'b0;
`endif
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_width;
  logic [31:0] mem_rdata = '0;

  typedef struct {
    logic        dbg;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t rdq[$];
  int      n_vec = 0;
  int      n_err = 0;
  int      exp_wait = 0;
  logic    mon_en = 1'b0;
  logic    last_core_gnt = 1'b0, last_dbg_gnt = 1'b0;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_width (core_width),
    .core_gnt   (core_gnt),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_width  (dbg_width),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
`ifdef DMEM_ARB_LOCK_EN
    .dbg_lock   (dbg_lock),
`endif
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_width  (mem_width),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory returns an address-derived word after a read, junk otherwise.
  always @(posedge clk) begin
    mem_rdata <= (mem_en && !mem_we) ? (mem_addr ^ RD_KEY) : $urandom;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic        eg_core, eg_dbg, lock;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_width;
    rd_exp_t     e;
    lock = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    lock = dbg_lock;
`endif
    if (reset) begin
      check_val("rst_core_gnt", 32'(core_gnt), 0);
      check_val("rst_dbg_gnt", 32'(dbg_gnt), 0);
      check_val("rst_mem_en", 32'(mem_en), 0);
      check_val("rst_mem_we", 32'(mem_we), 0);
      check_val("rst_mem_addr", mem_addr, 0);
      check_val("rst_mem_wdata", mem_wdata, 0);
      check_val("rst_mem_width", 32'(mem_width), 0);
      check_val("rst_core_rvalid", 32'(core_rvalid), 0);
      check_val("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
      check_val("rst_core_rdata", core_rdata, 0);
      check_val("rst_dbg_rdata", dbg_rdata, 0);
      rdq.delete();
      exp_wait = 0;
      last_core_gnt = 1'b0;
      last_dbg_gnt = 1'b0;
      return;
    end
    eg_dbg  = dbg_req && (lock || !core_req || exp_wait == MAX_WAIT);
    eg_core = core_req && !lock && !eg_dbg;
    e_we = 1'b0; e_addr = '0; e_wdata = '0; e_width = '0;
    if (eg_core) begin
      e_we = core_we; e_addr = core_addr; e_wdata = core_wdata; e_width = core_width;
    end else if (eg_dbg) begin
      e_we = dbg_we; e_addr = dbg_addr; e_wdata = dbg_wdata; e_width = dbg_width;
    end
    check_val("core_gnt", 32'(core_gnt), 32'(eg_core));
    check_val("dbg_gnt", 32'(dbg_gnt), 32'(eg_dbg));
    check_val("mem_en", 32'(mem_en), 32'(eg_core || eg_dbg));
    check_val("mem_we", 32'(mem_we), 32'(e_we));
    check_val("mem_addr", mem_addr, e_addr);
    check_val("mem_wdata", mem_wdata, e_wdata);
    check_val("mem_width", 32'(mem_width), 32'(e_width));
    if (rdq.size() > 0) begin
      e = rdq.pop_front();
      check_val("core_rvalid", 32'(core_rvalid), 32'(!e.dbg));
      check_val("dbg_rvalid", 32'(dbg_rvalid), 32'(e.dbg));
      check_val("core_rdata", core_rdata, e.dbg ? 32'h0 : e.data);
      check_val("dbg_rdata", dbg_rdata, e.dbg ? e.data : 32'h0);
    end else begin
      check_val("core_rvalid_idle", 32'(core_rvalid), 0);
      check_val("dbg_rvalid_idle", 32'(dbg_rvalid), 0);
      check_val("core_rdata_idle", core_rdata, 0);
      check_val("dbg_rdata_idle", dbg_rdata, 0);
    end
    if (eg_core && !core_we) rdq.push_back('{dbg: 1'b0, data: core_addr ^ RD_KEY});
    if (eg_dbg && !dbg_we)   rdq.push_back('{dbg: 1'b1, data: dbg_addr ^ RD_KEY});
    if (eg_dbg) exp_wait = 0;
    else if (dbg_req && exp_wait < MAX_WAIT) exp_wait++;
    last_core_gnt = eg_core;
    last_dbg_gnt  = eg_dbg;
  endtask

  always @(negedge clk) begin
    if (mon_en) monitor();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  ncore;
    logic seen_dbg;
    mon_en = 1'b1;
    // Requests held during reset must not reach the memory port.
    core_req = 1'b1; dbg_req = 1'b1; core_addr = 32'h40; dbg_addr = 32'h44;
    repeat (3) tick();
    reset = 1'b0; core_req = 1'b0; dbg_req = 1'b0;
    tick();

    // Single core read.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100; core_width = WIDTH_W;
    @(negedge clk);
    check_val("029_core_gnt", 32'(core_gnt), 1);
    check_val("029_mem_addr", mem_addr, 32'h100);
    tick();
    core_req = 1'b0;
    @(negedge clk);
    check_val("029_core_rvalid", 32'(core_rvalid), 1);
    check_val("029_core_rdata", core_rdata, 32'h100 ^ RD_KEY);
    tick();

    // Debug write with the core idle.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h200; dbg_wdata = 32'hDEADBEEF; dbg_width = WIDTH_W;
    @(negedge clk);
    check_val("031_dbg_gnt", 32'(dbg_gnt), 1);
    check_val("031_mem_we", 32'(mem_we), 1);
    check_val("031_mem_addr", mem_addr, 32'h200);
    check_val("031_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    dbg_req = 1'b0; dbg_we = 1'b0;
    @(negedge clk);
    check_val("031_no_rvalid", 32'(core_rvalid | dbg_rvalid), 0);
    tick();

    // Continuous contention: core should win exactly MAX_WAIT times first.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h1000;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h300;
    ncore = 0; seen_dbg = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_gnt) begin
        seen_dbg = 1'b1;
        break;
      end
      if (core_gnt) ncore++;
      tick();
      core_addr = 32'h1000 + 32'(4 * (i + 1));
    end
    check_val("030_dbg_gnt_seen", 32'(seen_dbg), 1);
    check_val("030_core_run", 32'(ncore), MAX_WAIT);
    tick();
    @(negedge clk);
    check_val("030_core_after", 32'(core_gnt), 1);
    check_val("030_dbg_rvalid", 32'(dbg_rvalid), 1);
    tick();
    core_req = 1'b0; dbg_req = 1'b0;
    tick();

    // Reset lands the cycle after a core read grant: the read is dropped.
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h180;
    @(negedge clk);
    check_val("032_core_gnt", 32'(core_gnt), 1);
    tick();
    core_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    check_val("032_rvalid_in_rst", 32'(core_rvalid), 0);
    check_val("032_rdata_in_rst", core_rdata, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_val("032_rvalid_after", 32'(core_rvalid), 0);
    tick();

`ifdef DMEM_ARB_LOCK_EN
    dbg_lock = 1'b1; core_req = 1'b1; dbg_req = 1'b1; core_we = 1'b0; dbg_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("033_core_locked", 32'(core_gnt), 0);
      check_val("033_dbg_locked", 32'(dbg_gnt), 1);
      tick();
      dbg_addr = 32'h400 + 32'(4 * i);
    end
    dbg_lock = 1'b0;
    @(negedge clk);
    check_val("033_core_unlock", 32'(core_gnt), 1);
    tick();
    core_req = 1'b0; dbg_req = 1'b0;
    tick();
`endif

    // Random traffic honouring the hold-until-grant rule, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (!core_req || last_core_gnt) begin
        core_req   = ($urandom_range(0, 2) != 0);
        core_we    = $urandom_range(0, 1) == 1;
        core_addr  = $urandom;
        core_wdata = $urandom;
        core_width = 3'($urandom_range(0, 5));
      end
      if (!dbg_req || last_dbg_gnt) begin
        dbg_req   = ($urandom_range(0, 1) == 1);
        dbg_we    = $urandom_range(0, 1) == 1;
        dbg_addr  = $urandom;
        dbg_wdata = $urandom;
        dbg_width = 3'($urandom_range(0, 5));
      end
      tick();
    end

    reset = 1'b0; core_req = 1'b0; dbg_req = 1'b0;
    repeat (3) tick();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
